// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and opcode encodings
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW = 3;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_RSVD = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: request, ALU and result ports of the issue stage
interface alu_issue_stage_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW = ALU_OPW
) ();
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_A, in_B;
  logic [OPW-1:0] in_op;
  logic [WIDTH-1:0] alu_A, alu_B, alu_R;
  logic [OPW-1:0] alu_op;
  logic out_valid, out_ready, out_zero, out_err;
  logic [WIDTH-1:0] out_R;
  modport master (
    output in_valid, in_A, in_B, in_op, alu_R, out_ready,
    input in_ready, alu_A, alu_B, alu_op, out_valid, out_R, out_zero, out_err
  );
  modport slave (
    input in_valid, in_A, in_B, in_op, alu_R, out_ready,
    output in_ready, alu_A, alu_B, alu_op, out_valid, out_R, out_zero, out_err
  );
endinterface

// File: rtl/alu_skid_reg.sv
// alu_skid_reg: one-entry skid buffer; o_ready is simply the registered empty flag
module alu_skid_reg #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic         i_drain,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  logic r_full;
  logic [W-1:0] r_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end
  assign o_full = r_full;
  assign o_ready = !r_full;
  assign o_data = r_data;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: skid -> issue (S1, drives ALU) -> result (S2) pipeline around an external ALU
module alu_issue_stage import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW = ALU_OPW
) (
  input logic clk,
  input logic rst_n,
  alu_issue_stage_if.slave bus
);
  localparam int PW = 2 * WIDTH + OPW;
  logic w_acc, w_s2_load, w_adv, w_s1_load, w_sk_full, w_sk_wr, w_sk_rd, w_sk_ready, w_rsvd;
  logic [PW-1:0] w_in_pkt, w_sk_pkt;
  logic r_s1_v, r_s2_v, r_s2_zero, r_s2_err;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_s2_r;
  logic [OPW-1:0] r_s1_op;
  assign w_acc = bus.in_valid && w_sk_ready;
  assign w_s2_load = !r_s2_v || bus.out_ready;
  assign w_adv = r_s1_v && w_s2_load;
  assign w_s1_load = !r_s1_v || w_adv;
  // SK is only written when empty, so it only catches inputs S1 cannot take
  assign w_sk_wr = w_acc && !w_s1_load;
  assign w_sk_rd = w_s1_load && w_sk_full;
  assign w_in_pkt = {bus.in_op, bus.in_A, bus.in_B};
  assign w_rsvd = r_s1_op == OPW'(ALU_RSVD);
  alu_skid_reg #(.W(PW)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(w_sk_wr),
    .i_drain(w_sk_rd),
    .i_data(w_in_pkt),
    .o_ready(w_sk_ready),
    .o_full(w_sk_full),
    .o_data(w_sk_pkt)
  );
  // S1 payload is cleared when it empties so the ALU ports read zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      {r_s1_op, r_s1_a, r_s1_b} <= '0;
    end else if (w_s1_load) begin
      r_s1_v <= w_sk_full || w_acc;
      {r_s1_op, r_s1_a, r_s1_b} <= w_sk_full ? w_sk_pkt : w_acc ? w_in_pkt : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_s2_r <= '0;
      r_s2_zero <= 1'b0;
      r_s2_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= w_adv;
      if (w_adv) begin
        r_s2_r <= w_rsvd ? '0 : bus.alu_R;
        r_s2_zero <= w_rsvd || bus.alu_R == '0;
        r_s2_err <= w_rsvd;
      end
    end
  end
  assign bus.in_ready = w_sk_ready;
  assign bus.alu_A = r_s1_a;
  assign bus.alu_B = r_s1_b;
  assign bus.alu_op = r_s1_op;
  assign bus.out_valid = r_s2_v;
  assign bus.out_R = r_s2_r;
  assign bus.out_zero = r_s2_zero;
  assign bus.out_err = r_s2_err;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipelined issue/retire wrapper around the MIPS32 combinational ALU datapath (bitwise AND/OR/XOR/NOR units, adder/subtractor, SLT).
- Upstream side: accepts operand/opcode requests over a valid/ready handshake, buffers them in a one-entry skid register and an issue register, and drives the issue register onto the ALU inputs.
- Downstream side: captures the ALU result one cycle later into a result register, with zero and illegal-op flags, and presents it over a second valid/ready handshake.
- Sits between the decode/operand-fetch stage and the ALU, and between the ALU and writeback.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready; registered
- in_A  in  WIDTH  operand A
- in_B  in  WIDTH  operand B
- in_op  in  OPW  opcode
- alu_A  out  WIDTH  issue-register operand A to ALU
- alu_B  out  WIDTH  issue-register operand B to ALU
- alu_op  out  OPW  issue-register opcode to ALU
- alu_R  in  WIDTH  combinational ALU result for alu_A/alu_B/alu_op
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_R  out  WIDTH  result
- out_zero  out  1  out_R == 0
- out_err  out  1  opcode was reserved

## Operation
Opcodes:
- 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT.
- 101 is reserved.

Three storage slots, in order from input to output:
- Skid register (SK).
- Issue register (S1), which drives alu_*.
- Result register (S2), which drives out_*.

Advance rules, all evaluated in the same cycle:
- s2_load = !out_valid || out_ready.
- S1 → S2 when S1 valid && s2_load.
  - S2 captures alu_R, zero = (alu_R == 0), err = (op == 101).
  - For a reserved op, S2 forces out_R = 0, out_zero = 1, out_err = 1.
- S1 loads when S1 is empty or S1 → S2 this cycle:
  - source is SK if SK is full, otherwise the accepted input.
- An accepted input goes to SK when S1 cannot take it this cycle, or when SK is full and draining into S1.
  - Acceptance itself is gated by in_ready, so SK never overflows.
- in_ready = !SK_full (registered).
- Order is strictly FIFO; no request is dropped or duplicated.

Output and ALU-port rules:
- out_* hold stable while out_valid && !out_ready.
- alu_A/alu_B/alu_op are 0 whenever S1 is empty.

Reset values (rst_n low at an edge):
- in_ready = 1.
- out_valid = 0, out_R = 0, out_zero = 0, out_err = 0.
- alu_A = 0, alu_B = 0, alu_op = 0.
- All slot valids = 0.

## Timing
- Latency: a request accepted at edge k into an empty S1 shows out_valid = 1 after edge k+1 (visible in cycle k+1..k+2). The ALU has one full cycle from S1.
- Throughput: with out_ready held at 1, one result per cycle; in_ready stays 1.
- Backpressure:
  - out_ready = 0 with S1 and S2 full: the next accepted request lands in SK, and in_ready drops to 0 after that edge.
  - Capacity is 3 in flight (SK, S1, S2).
- Release: out_ready rising with all three slots full shifts S1→S2 and SK→S1 on the same edge. in_ready returns to 1 after that edge.
- Simultaneous events:
  - If out consume, S1 advance and input accept all happen on one edge, all three occur.
  - An input is never accepted on a cycle in which in_ready = 0, regardless of in_valid.
- Reset mid-operation: any rst_n low edge discards all in-flight requests. No out_valid pulse is emitted for them.
- Inputs in_A/in_B/in_op are sampled only on the accept edge. They may change otherwise.

## Structure
- Shared package alu_pkg:
  - WIDTH/OPW defaults.
  - Opcode localparams (ALU_AND … ALU_SLT, ALU_RSVD = 3'b101).
  - Used by this stage, the ALU control decoder and the bench.
- One sub-module: alu_skid_reg, a one-entry skid buffer with valid/ready.
- The top holds S1/S2 and the advance logic. The combinational ALU stays external and is connected through alu_A/alu_B/alu_op/alu_R.

## Test plan
- Reset: hold rst_n = 0 two cycles → in_ready = 1, out_valid = 0, out_R = 0, alu_A = alu_B = 0.
- Single XOR, bench ALU connected: A = 0xFFFF0000, B = 0x0F0F0F0F, op = 011 → out_valid two edges after accept, out_R = 0xF0F00F0F, out_zero = 0, out_err = 0.
- Zero flag and reserved op:
  - ADD 0x00000005 + 0xFFFFFFFB → out_R = 0, out_zero = 1.
  - op = 101 → out_R = 0, out_zero = 1, out_err = 1.
- Backpressure:
  - Stream XORs of A = i, B = 0 with out_ready = 0 → exactly 3 accepted, then in_ready = 0.
  - Raise out_ready → results 0, 1, 2, 3… in order with no loss, and in_ready = 1 one edge after the release.
- Full throughput: 100 back-to-back random ops with out_ready = 1 → one result per cycle, each matching the reference model.
- Reset mid-stream: assert rst_n = 0 with 3 in flight → after the edge out_valid = 0 and in_ready = 1, and no stale result appears afterward.
